// File: rtl/tdp_ram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes, optional
// output registers, collision flag and a clear engine that sweeps the array to INIT_VALUE.
module tdp_ram_be_clr #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 9,
    parameter int                    BYTE_WIDTH     = 8,
    parameter string                 WRITE_MODE_A   = "READ_FIRST",
    parameter string                 WRITE_MODE_B   = "READ_FIRST",
    parameter string                 OUTPUT_REG_A   = "FALSE",
    parameter string                 OUTPUT_REG_B   = "FALSE",
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_req,
    output logic                             busy,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            din_a,
    output logic [DATA_WIDTH-1:0]            dout_a,
    output logic                             vld_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            din_b,
    output logic [DATA_WIDTH-1:0]            dout_b,
    output logic                             vld_b,
    output logic                             collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] MODE_RF = 2'd0;
    localparam logic [1:0] MODE_WF = 2'd1;
    localparam logic [1:0] MODE_NC = 2'd2;

    localparam logic [1:0] MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? MODE_WF :
                                    (WRITE_MODE_A == "NO_CHANGE")   ? MODE_NC : MODE_RF;
    localparam logic [1:0] MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? MODE_WF :
                                    (WRITE_MODE_B == "NO_CHANGE")   ? MODE_NC : MODE_RF;
    localparam bit OREG_A = (OUTPUT_REG_A == "TRUE");
    localparam bit OREG_B = (OUTPUT_REG_B == "TRUE");

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         lane_we
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lane_we[i]) begin
                result[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return result;
    endfunction

    // A port that only reads always sees the stored (pre-write) word.
    function automatic logic [DATA_WIDTH-1:0] port_rdata(
        input logic [1:0]            mode,
        input logic                  writing,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] own_word,
        input logic [DATA_WIDTH-1:0] prev_dout
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        if (writing) begin
            case (mode)
                MODE_WF: result = own_word;
                MODE_NC: result = prev_dout;
                default: result = old_word;
            endcase
        end
        return result;
    endfunction

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a, acc_b;
    logic                  wen_a, wen_b;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    logic [DATA_WIDTH-1:0] own_a, own_b;
    logic [DATA_WIDTH-1:0] wr_word_a;

    logic [DATA_WIDTH-1:0] dout1_a_q, dout1_a_d;
    logic [DATA_WIDTH-1:0] dout1_b_q, dout1_b_d;
    logic                  vld1_a_q, vld1_a_d;
    logic                  vld1_b_q, vld1_b_d;
    logic                  collision_q, collision_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // clr_req during a sweep is ignored; the counter only wraps on the way out of CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == CLEAR);
        clr_we = (state_q == CLEAR);
    end

    always_comb begin
        acc_a     = en_a & ~busy;
        acc_b     = en_b & ~busy;
        same_addr = acc_a & acc_b & (addr_a == addr_b);
        wen_a     = acc_a & (|we_a);
        wen_b     = acc_b & (|we_b) & ~(same_addr & wen_a);
        rd_a      = mem[addr_a];
        rd_b      = mem[addr_b];
        own_a     = merge_lanes(rd_a, din_a, we_a);
        own_b     = merge_lanes(rd_b, din_b, we_b);
        // On a shared address port A's write carries B's lanes too, with A winning overlaps.
        wr_word_a = merge_lanes(same_addr ? own_b : rd_a, din_a, we_a);
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= INIT_VALUE;
        end else begin
            if (wen_a) begin
                mem[addr_a] <= wr_word_a;
            end
            if (wen_b) begin
                mem[addr_b] <= own_b;
            end
        end
    end

    always_comb begin
        dout1_a_d   = dout1_a_q;
        dout1_b_d   = dout1_b_q;
        vld1_a_d    = acc_a;
        vld1_b_d    = acc_b;
        collision_d = same_addr & ((|we_a) | (|we_b));
        if (acc_a) begin
            dout1_a_d = port_rdata(MODE_A, |we_a, rd_a, own_a, dout1_a_q);
        end
        if (acc_b) begin
            dout1_b_d = port_rdata(MODE_B, |we_b, rd_b, own_b, dout1_b_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1_a_q   <= '0;
            dout1_b_q   <= '0;
            vld1_a_q    <= 1'b0;
            vld1_b_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            dout1_a_q   <= dout1_a_d;
            dout1_b_q   <= dout1_b_d;
            vld1_a_q    <= vld1_a_d;
            vld1_b_q    <= vld1_b_d;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

    generate
        if (OREG_A) begin : g_oreg_a
            logic [DATA_WIDTH-1:0] dout2_a_q;
            logic                  vld2_a_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout2_a_q <= '0;
                    vld2_a_q  <= 1'b0;
                end else begin
                    dout2_a_q <= dout1_a_q;
                    vld2_a_q  <= vld1_a_q;
                end
            end
            assign dout_a = dout2_a_q;
            assign vld_a  = vld2_a_q;
        end else begin : g_direct_a
            assign dout_a = dout1_a_q;
            assign vld_a  = vld1_a_q;
        end

        if (OREG_B) begin : g_oreg_b
            logic [DATA_WIDTH-1:0] dout2_b_q;
            logic                  vld2_b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout2_b_q <= '0;
                    vld2_b_q  <= 1'b0;
                end else begin
                    dout2_b_q <= dout1_b_q;
                    vld2_b_q  <= vld1_b_q;
                end
            end
            assign dout_b = dout2_b_q;
            assign vld_b  = vld2_b_q;
        end else begin : g_direct_b
            assign dout_b = dout1_b_q;
            assign vld_b  = vld1_b_q;
        end
    endgenerate

endmodule

// File: tb/tb_tdp_ram_be_clr.sv
// Bench for tdp_ram_be_clr: three instances with different write-mode/output-register mixes
// share one stimulus stream; a reference memory feeds a due-cycle scoreboard.
module tb_tdp_ram_be_clr;

    localparam logic [31:0] INIT = 32'hA5A5A5A5;
    localparam int NI = 3;

    typedef struct {
        logic        en_a;
        logic [3:0]  we_a;
        logic [3:0]  addr_a;
        logic [31:0] din_a;
        logic        en_b;
        logic [3:0]  we_b;
        logic [3:0]  addr_b;
        logic [31:0] din_b;
        logic        exp_coll;
    } vec_t;

    typedef struct {
        int          due;
        int          inst;
        int          port;
        logic [31:0] data;
    } sb_t;

    // 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE; must match the instances below.
    int mode_a [NI] = '{0, 1, 2};
    int mode_b [NI] = '{0, 2, 1};
    int oreg_a [NI] = '{0, 1, 1};
    int oreg_b [NI] = '{1, 0, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;

    logic [NI-1:0] busy, vld_a, vld_b, coll;
    logic [31:0]   dout_a [NI];
    logic [31:0]   dout_b [NI];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    sb_t         sb [$];
    bit          coll_due [int];
    logic [31:0] ref_mem [16];
    logic [31:0] last_exp [NI][2];
    logic [31:0] shown [NI][2];
    vec_t        tbl [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tdp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
        .OUTPUT_REG_A("FALSE"), .OUTPUT_REG_B("TRUE"),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy[0]),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[0]), .vld_a(vld_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[0]), .vld_b(vld_b[0]),
        .collision(coll[0]));

    tdp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
        .OUTPUT_REG_A("TRUE"), .OUTPUT_REG_B("FALSE"),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy[1]),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[1]), .vld_a(vld_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[1]), .vld_b(vld_b[1]),
        .collision(coll[1]));

    tdp_ram_be_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
        .OUTPUT_REG_A("TRUE"), .OUTPUT_REG_B("FALSE"),
        .INIT_VALUE(INIT), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy[2]),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a[2]), .vld_a(vld_a[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b[2]), .vld_b(vld_b[2]),
        .collision(coll[2]));

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic vec_t mk(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                                input logic [31:0] da, input logic eb, input logic [3:0] wb,
                                input logic [3:0] ab, input logic [31:0] db, input logic ec);
        vec_t v;
        v.en_a = ea; v.we_a = wa; v.addr_a = aa; v.din_a = da;
        v.en_b = eb; v.we_b = wb; v.addr_b = ab; v.din_b = db;
        v.exp_coll = ec;
        return v;
    endfunction

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] din,
                                              input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (we[l]) r[l*8 +: 8] = din[l*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] portExpect(input int mode, input logic [31:0] old,
                                               input logic [31:0] din, input logic [3:0] we,
                                               input logic [31:0] prev);
        if (we == 4'b0000) return old;
        case (mode)
            1:       return mergeWord(old, din, we);
            2:       return prev;
            default: return old;
        endcase
    endfunction

    // Drives one cycle of stimulus; when the access is expected to be accepted the
    // reference memory is updated and the expected outputs are queued with their due cycle.
    task automatic applyStimulus(input vec_t v, input bit accept, input bit req);
        logic [31:0] old_a, old_b, e;
        @(posedge clk);
        #1;
        en_a = v.en_a; we_a = v.we_a; addr_a = v.addr_a; din_a = v.din_a;
        en_b = v.en_b; we_b = v.we_b; addr_b = v.addr_b; din_b = v.din_b;
        clr_req = req;
        if (accept) begin
            old_a = ref_mem[v.addr_a];
            old_b = ref_mem[v.addr_b];
            for (int i = 0; i < NI; i++) begin
                if (v.en_a) begin
                    e = portExpect(mode_a[i], old_a, v.din_a, v.we_a, last_exp[i][0]);
                    last_exp[i][0] = e;
                    sb.push_back('{cyc + 1 + oreg_a[i], i, 0, e});
                end
                if (v.en_b) begin
                    e = portExpect(mode_b[i], old_b, v.din_b, v.we_b, last_exp[i][1]);
                    last_exp[i][1] = e;
                    sb.push_back('{cyc + 1 + oreg_b[i], i, 1, e});
                end
            end
            if (v.en_b && v.we_b != 4'b0000) ref_mem[v.addr_b] = mergeWord(old_b, v.din_b, v.we_b);
            if (v.en_a && v.we_a != 4'b0000)
                ref_mem[v.addr_a] = mergeWord(ref_mem[v.addr_a], v.din_a, v.we_a);
            if (v.exp_coll) coll_due[cyc + 1] = 1'b1;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
    endtask

    task automatic resetAndSweep();
        int bc [NI];
        @(posedge clk);
        #1;
        rst = 1'b1;
        en_a = 1'b0; en_b = 1'b0; clr_req = 1'b0;
        sb.delete();
        coll_due.delete();
        for (int i = 0; i < NI; i++) begin
            last_exp[i][0] = '0; last_exp[i][1] = '0;
            shown[i][0] = '0;    shown[i][1] = '0;
            bc[i] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) checkOutput($sformatf("busy_in_reset%0d", i), 32'(busy[i]), 32'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (busy[i]) bc[i]++;
        end
        for (int i = 0; i < NI; i++) checkOutput($sformatf("reset_sweep_len%0d", i), 32'(bc[i]), 32'd16);
        for (int a = 0; a < 16; a++) ref_mem[a] = INIT;
    endtask

    task automatic readAll();
        for (int a = 0; a < 16; a++)
            applyStimulus(mk(1, 0, 4'(a), 0, 1, 0, 4'(15 - a), 0, 0), 1, 0);
    endtask

    // Each cycle: vld must match a due scoreboard entry, dout must equal that entry or hold.
    always @(negedge clk) begin : monitor
        logic        v;
        logic [31:0] d, want;
        int          idx;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                v = (p == 0) ? vld_a[i] : vld_b[i];
                d = (p == 0) ? dout_a[i] : dout_b[i];
                idx = -1;
                foreach (sb[k]) if (idx < 0 && sb[k].inst == i && sb[k].port == p && sb[k].due == cyc) idx = k;
                checkOutput($sformatf("vld i%0d p%0d", i, p), 32'(v), 32'(idx >= 0));
                if (idx >= 0) begin
                    want = sb[idx].data;
                    shown[i][p] = want;
                    sb.delete(idx);
                end else begin
                    want = shown[i][p];
                end
                checkOutput($sformatf("dout i%0d p%0d", i, p), d, want);
            end
            checkOutput($sformatf("collision i%0d", i), 32'(coll[i]), 32'(coll_due.exists(cyc)));
        end
    end

    initial begin
        int bc [NI];
        tbl.push_back(mk(1, 4'hF, 3, 32'h11223344, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h5, 3, 32'hAABBCCDD, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 3, 0, 1, 4'h0, 3, 0, 0));
        tbl.push_back(mk(1, 4'hF, 7, 32'h00000000, 1, 4'h3, 7, 32'hFFFFFFFF, 1));
        tbl.push_back(mk(1, 4'h0, 7, 0, 1, 4'h0, 7, 0, 0));
        tbl.push_back(mk(1, 4'hC, 7, 32'hFFFFFFFF, 1, 4'h0, 7, 0, 1));
        tbl.push_back(mk(1, 4'h0, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4'hA, 9, 32'h12345678, 0));
        tbl.push_back(mk(1, 4'hF, 10, 32'hDEADBEEF, 1, 4'h5, 9, 32'hCAFEF00D, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 10, 0, 1, 4'h1, 10, 32'h000000EE, 1));
        tbl.push_back(mk(1, 4'h0, 9, 0, 1, 4'h0, 10, 0, 0));
        tbl.push_back(mk(1, 4'hF, 2, 32'h01020304, 1, 4'hF, 2, 32'hF0F0F0F0, 1));
        tbl.push_back(mk(1, 4'h0, 2, 0, 1, 4'h0, 2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 2, 32'h99887766, 1, 4'hC, 2, 32'h55443322, 1));
        tbl.push_back(mk(1, 4'h0, 2, 0, 1, 4'h0, 2, 0, 0));

        #1 rst = 1'b1;
        resetAndSweep();
        readAll();

        foreach (tbl[r]) applyStimulus(tbl[r], 1, 0);
        idleCycles(3);

        // Clear request alongside an accepted colliding access, then blocked traffic.
        for (int i = 0; i < NI; i++) bc[i] = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 0)
                applyStimulus(mk(1, 4'hF, 4, 32'h0BADF00D, 1, 4'h0, 4, 0, 1), 1, 1);
            else if (k <= 16)
                applyStimulus(mk(1, 4'hF, 4'(k - 1), 32'(k), 1, 4'h3, 4'(k), 32'h5A5A5A5A, 0), 0, k == 5);
            else
                applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0);
            @(negedge clk);
            for (int i = 0; i < NI; i++) if (busy[i]) bc[i]++;
        end
        for (int i = 0; i < NI; i++) checkOutput($sformatf("req_sweep_len%0d", i), 32'(bc[i]), 32'd16);
        for (int a = 0; a < 16; a++) ref_mem[a] = INIT;
        readAll();

        applyStimulus(mk(1, 4'hF, 6, 32'h13579BDF, 0, 0, 0, 0, 0), 1, 0);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1);
        idleCycles(5);
        resetAndSweep();
        applyStimulus(mk(1, 4'h0, 6, 0, 0, 0, 0, 0, 0), 1, 0);

        applyStimulus(mk(1, 4'h0, 1, 0, 1, 4'hF, 1, 32'h55555555, 1), 1, 0);
        resetAndSweep();
        applyStimulus(mk(1, 4'h0, 1, 0, 1, 4'h0, 6, 0, 0), 1, 0);
        idleCycles(4);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
